// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage LC-3b pipeline: register load/clear
// control, LDI/STI double-access tracking, fetch holding buffer and perf counters.
module pipe_hazard_ctrl #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 imem_req,
    input  logic                 imem_resp,
    input  logic                 dmem_req,
    input  logic                 dmem_indirect,
    input  logic                 dmem_resp,
    input  logic                 load_use,
    input  logic                 mispredict,
    output logic                 imem_go,
    output logic                 indirect_phase,
    output logic                 if_buf_load,
    output logic                 if_id_from_buf,
    output logic                 pc_redirect,
    output logic                 load_pc,
    output logic                 load_if_id,
    output logic                 load_id_ex,
    output logic                 load_ex_mem,
    output logic                 load_mem_wb,
    output logic                 clear_if_id,
    output logic                 clear_id_ex,
    output logic                 clear_ex_mem,
    output logic                 clear_mem_wb,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    typedef enum logic {
        M_IDLE,
        M_IND2
    } mem_state_e;

    mem_state_e           state_q, state_d;
    logic                 fetch_done_q, fetch_done_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic mem_busy;
    logic fetch_ready;
    logic redirect;

    assign indirect_phase = (state_q == M_IND2);
    assign mem_busy       = dmem_req & ~(dmem_resp & (~dmem_indirect | indirect_phase));
    assign fetch_ready    = fetch_done_q | imem_resp | ~imem_req;
    assign if_id_from_buf = fetch_done_q;
    assign imem_go        = ~reset & imem_req & ~fetch_done_q;
    assign if_buf_load    = ~reset & imem_resp & ~load_if_id;

    // Priority-ordered hazard resolution; the first matching condition owns the cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // if-chain can leave a signal unassigned and infer a latch.
        load_pc      = 1'b0;
        load_if_id   = 1'b0;
        load_id_ex   = 1'b0;
        load_ex_mem  = 1'b0;
        load_mem_wb  = 1'b0;
        clear_if_id  = 1'b0;
        clear_id_ex  = 1'b0;
        clear_ex_mem = 1'b0;
        clear_mem_wb = 1'b0;
        redirect     = 1'b0;

        if (reset) begin
            clear_if_id  = 1'b1;
            clear_id_ex  = 1'b1;
            clear_ex_mem = 1'b1;
            clear_mem_wb = 1'b1;
        end else if (mem_busy) begin
            load_mem_wb  = 1'b1;
            clear_mem_wb = 1'b1;
        end else if (mispredict && fetch_ready) begin
            redirect     = 1'b1;
            load_pc      = 1'b1;
            load_if_id   = 1'b1;
            load_id_ex   = 1'b1;
            load_ex_mem  = 1'b1;
            load_mem_wb  = 1'b1;
            clear_if_id  = 1'b1;
            clear_id_ex  = 1'b1;
            clear_ex_mem = 1'b1;
        end else if (mispredict) begin
            // The redirect waits for the in-flight fetch so its response is not orphaned.
            load_mem_wb  = 1'b1;
            clear_mem_wb = 1'b1;
        end else if (!fetch_ready || load_use) begin
            load_pc      = 1'b0;
            load_if_id   = load_pc;
            load_id_ex   = 1'b1;
            clear_id_ex  = 1'b1;
            load_ex_mem  = 1'b1;
            load_mem_wb  = 1'b1;
        end else begin
            load_pc      = 1'b1;
            load_if_id   = load_pc;
            load_id_ex   = 1'b1;
            load_ex_mem  = 1'b1;
            load_mem_wb  = 1'b1;
        end
    end

    assign pc_redirect = redirect;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            M_IDLE: if (dmem_req && dmem_indirect && dmem_resp) state_d = M_IND2;
            M_IND2: if (dmem_resp || !dmem_req)                 state_d = M_IDLE;
            default:                                            state_d = M_IDLE;
        endcase
    end

    // A redirect discards any buffered wrong-path word; clear beats set.
    always_comb begin
        fetch_done_d = fetch_done_q;
        if (load_if_id || redirect) begin
            fetch_done_d = 1'b0;
        end else if (if_buf_load) begin
            fetch_done_d = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!load_pc && stall_cnt_q != {CNT_WIDTH{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (redirect && flush_cnt_q != {CNT_WIDTH{1'b1}}) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= M_IDLE;
            fetch_done_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            fetch_done_q <= fetch_done_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl; a narrow-counter second
// instance shares the stimulus to exercise counter saturation.
module tb_pipe_hazard_ctrl;

    // Load/clear patterns: {load_pc, if_id, id_ex, ex_mem, mem_wb, clear_if_id, id_ex, ex_mem, mem_wb}
    localparam logic [8:0] ADV  = 9'b11111_0000;
    localparam logic [8:0] MEMS = 9'b00001_0001;
    localparam logic [8:0] REDR = 9'b11111_1110;
    localparam logic [8:0] BUBL = 9'b00111_0100;
    localparam logic [8:0] RSTP = 9'b00000_1111;

    // Inputs: {imem_req, imem_resp, dmem_req, dmem_indirect, dmem_resp, load_use, mispredict}
    // Misc:   {imem_go, indirect_phase, if_buf_load, if_id_from_buf, pc_redirect}
    typedef struct {
        logic [6:0]  in;
        logic [4:0]  misc;
        logic [8:0]  lc;
        logic [15:0] stall;
        logic [15:0] flush;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic imem_req, imem_resp, dmem_req, dmem_indirect, dmem_resp, load_use, mispredict;
    logic imem_go, indirect_phase, if_buf_load, if_id_from_buf, pc_redirect;
    logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic clear_if_id, clear_id_ex, clear_ex_mem, clear_mem_wb;
    logic [15:0] stall_count, flush_count;
    wire  [13:0] s_ctrl;
    logic [2:0]  s_stall, s_flush;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_resp(imem_resp), .dmem_req(dmem_req),
        .dmem_indirect(dmem_indirect), .dmem_resp(dmem_resp),
        .load_use(load_use), .mispredict(mispredict),
        .imem_go(imem_go), .indirect_phase(indirect_phase), .if_buf_load(if_buf_load),
        .if_id_from_buf(if_id_from_buf), .pc_redirect(pc_redirect),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .clear_if_id(clear_if_id), .clear_id_ex(clear_id_ex),
        .clear_ex_mem(clear_ex_mem), .clear_mem_wb(clear_mem_wb),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipe_hazard_ctrl #(.CNT_WIDTH(3)) dut_sat (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_resp(imem_resp), .dmem_req(dmem_req),
        .dmem_indirect(dmem_indirect), .dmem_resp(dmem_resp),
        .load_use(load_use), .mispredict(mispredict),
        .imem_go(s_ctrl[0]), .indirect_phase(s_ctrl[1]), .if_buf_load(s_ctrl[2]),
        .if_id_from_buf(s_ctrl[3]), .pc_redirect(s_ctrl[4]),
        .load_pc(s_ctrl[5]), .load_if_id(s_ctrl[6]), .load_id_ex(s_ctrl[7]),
        .load_ex_mem(s_ctrl[8]), .load_mem_wb(s_ctrl[9]),
        .clear_if_id(s_ctrl[10]), .clear_id_ex(s_ctrl[11]),
        .clear_ex_mem(s_ctrl[12]), .clear_mem_wb(s_ctrl[13]),
        .stall_count(s_stall), .flush_count(s_flush)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] v);
        {imem_req, imem_resp, dmem_req, dmem_indirect, dmem_resp, load_use, mispredict} = v;
    endtask

    task automatic check_outs(input string tag, input logic [4:0] misc, input logic [8:0] lc,
                              input logic [15:0] st, input logic [15:0] fl);
        check({tag, " misc"}, {27'd0, imem_go, indirect_phase, if_buf_load, if_id_from_buf, pc_redirect},
              {27'd0, misc});
        check({tag, " ld/clr"}, {23'd0, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
              clear_if_id, clear_id_ex, clear_ex_mem, clear_mem_wb}, {23'd0, lc});
        check({tag, " stall_count"}, {16'd0, stall_count}, {16'd0, st});
        check({tag, " flush_count"}, {16'd0, flush_count}, {16'd0, fl});
    endtask

    // Apply one cycle of inputs at the falling edge and check just after.
    task automatic step(input string tag, input logic [6:0] v, input logic [4:0] misc,
                        input logic [8:0] lc, input logic [15:0] st, input logic [15:0] fl);
        @(negedge clk);
        drive(v);
        #1;
        check_outs(tag, misc, lc, st, fl);
    endtask

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{7'b1100000, 5'b10000, ADV,  16'd0, 16'd0};
        tbl[1]  = '{7'b1100000, 5'b10000, ADV,  16'd0, 16'd0};
        tbl[2]  = '{7'b1100000, 5'b10000, ADV,  16'd0, 16'd0};
        tbl[3]  = '{7'b1100000, 5'b10000, ADV,  16'd0, 16'd0};
        tbl[4]  = '{7'b1100000, 5'b10000, ADV,  16'd0, 16'd0};
        tbl[5]  = '{7'b0010000, 5'b00000, MEMS, 16'd0, 16'd0};
        tbl[6]  = '{7'b0010000, 5'b00000, MEMS, 16'd1, 16'd0};
        tbl[7]  = '{7'b0010000, 5'b00000, MEMS, 16'd2, 16'd0};
        tbl[8]  = '{7'b0010100, 5'b00000, ADV,  16'd3, 16'd0};
        tbl[9]  = '{7'b0000010, 5'b00000, BUBL, 16'd3, 16'd0};
        tbl[10] = '{7'b0000000, 5'b00000, ADV,  16'd4, 16'd0};
        tbl[11] = '{7'b0000001, 5'b00001, REDR, 16'd4, 16'd0};
        tbl[12] = '{7'b1000000, 5'b10000, BUBL, 16'd4, 16'd1};
        tbl[13] = '{7'b0000000, 5'b00000, ADV,  16'd5, 16'd1};

        reset = 1'b1;
        drive(7'b1100000);
        #2;
        check_outs("reset", 5'b00000, RSTP, 16'd0, 16'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            step($sformatf("vec%0d", i), tbl[i].in, tbl[i].misc, tbl[i].lc, tbl[i].stall, tbl[i].flush);
        end

        // LDI: responses on cycles 2 and 5, second-access phase on cycles 3-5.
        step("ldi c1", 7'b0011000, 5'b00000, MEMS, 16'd5, 16'd1);
        step("ldi c2", 7'b0011100, 5'b00000, MEMS, 16'd6, 16'd1);
        step("ldi c3", 7'b0011000, 5'b01000, MEMS, 16'd7, 16'd1);
        step("ldi c4", 7'b0011000, 5'b01000, MEMS, 16'd8, 16'd1);
        step("ldi c5", 7'b0011100, 5'b01000, ADV,  16'd9, 16'd1);
        step("ldi c6", 7'b0000000, 5'b00000, ADV,  16'd9, 16'd1);

        // Fetch returns during a MEM stall and is replayed from the buffer.
        step("fbuf a", 7'b1110000, 5'b10100, MEMS, 16'd9,  16'd1);
        step("fbuf b", 7'b1010000, 5'b00010, MEMS, 16'd10, 16'd1);
        step("fbuf c", 7'b1010100, 5'b00010, ADV,  16'd11, 16'd1);
        step("fbuf d", 7'b1000000, 5'b10000, BUBL, 16'd11, 16'd1);

        // Mispredict with a fetch in flight: redirect waits for the response.
        step("mp e", 7'b1000001, 5'b10000, MEMS, 16'd12, 16'd1);
        step("mp f", 7'b1000001, 5'b10000, MEMS, 16'd13, 16'd1);
        step("mp g", 7'b1100001, 5'b10001, REDR, 16'd14, 16'd1);
        step("mp h", 7'b0000000, 5'b00000, ADV,  16'd14, 16'd2);

        // Eight back-to-back redirects push the 3-bit counters to saturation.
        for (int i = 0; i < 8; i++) begin
            step($sformatf("redir%0d", i), 7'b0000001, 5'b00001, REDR, 16'd14, 16'(2 + i));
        end
        step("post redir", 7'b0000000, 5'b00000, ADV, 16'd14, 16'd10);
        check("sat stall", {29'd0, s_stall}, 32'd7);
        check("sat flush", {29'd0, s_flush}, 32'd7);

        // Reset asserted while the FSM sits in the second indirect access.
        step("rst i", 7'b0011100, 5'b00000, MEMS, 16'd14, 16'd10);
        step("rst j", 7'b0011000, 5'b01000, MEMS, 16'd15, 16'd10);
        #2;
        reset = 1'b1;
        #1;
        check_outs("in reset", 5'b00000, RSTP, 16'd0, 16'd0);
        check("sat stall rst", {29'd0, s_stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(7'b0000000);
        #1;
        check_outs("after reset", 5'b00000, ADV, 16'd0, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
